// File: rtl/switch_pkg.sv
// Shared definitions for the switch forwarding controller:
// FSM encoding, broadcast fill bit and port-address slicing.
package switch_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_FWD    = 3'd3;
    localparam logic [2:0] ST_DROP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DECODE = ST_DECODE,
        S_WAIT   = ST_WAIT,
        S_FWD    = ST_FWD,
        S_DROP   = ST_DROP
    } state_t;

    // Broadcast address is this bit replicated across the address width.
    localparam logic BCAST_BIT = 1'b1;

    function automatic int unsigned port_lsb(
        input int unsigned idx,
        input int unsigned width
    );
        return idx * width;
    endfunction

endpackage

// File: rtl/switch_wdog.sv
// Stall watchdog: reloaded on feed, counts down while armed and
// flags expiry in its last armed cycle; idles at zero when disarmed.
module switch_wdog
    import switch_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic feed,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (feed) begin
            cnt_d = CW'(TIMEOUT);
        end else if (!arm) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign expire = arm && (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/switch_fwd_ctrl.sv
// Multi-port forwarding controller: decodes the header beat to an
// egress port set and streams the packet under per-port back-pressure.
module switch_fwd_ctrl
    import switch_pkg::*;
#(
    parameter int W_WIDTH   = 8,
    parameter int NUM_PORTS = 4,
    parameter int TIMEOUT   = 16,
    parameter bit BCAST_EN  = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           sw_en,
    input  logic                           sw_last,
    input  logic [W_WIDTH-1:0]             data_in,
    output logic                           sw_ready,
    input  logic [NUM_PORTS*W_WIDTH-1:0]   port_addr,
    input  logic [NUM_PORTS-1:0]           port_busy,
    output logic [NUM_PORTS-1:0]           wr_en,
    output logic [W_WIDTH-1:0]             data_out,
    output logic                           drop,
    output logic                           wd_timeout
);

    state_t               state_q;
    state_t               state_d;
    logic [W_WIDTH-1:0]   hdr_q;
    logic [W_WIDTH-1:0]   hdr_d;
    logic                 hdr_last_q;
    logic                 hdr_last_d;
    logic [NUM_PORTS-1:0] sel_q;
    logic [NUM_PORTS-1:0] sel_d;
    logic [NUM_PORTS-1:0] wr_en_q;
    logic [NUM_PORTS-1:0] wr_en_d;
    logic [W_WIDTH-1:0]   data_out_q;
    logic [W_WIDTH-1:0]   data_out_d;
    logic                 drop_q;
    logic                 drop_d;
    logic                 wd_timeout_q;
    logic                 wd_timeout_d;

    logic [NUM_PORTS-1:0] dec_sel;
    logic                 dec_hit;
    logic                 egress_free;
    logic                 ready;
    logic                 wd_arm;
    logic                 wd_feed;
    logic                 wd_expire;

    assign egress_free = ~|(port_busy & sel_q);

    // Lowest matching index wins; broadcast overrides any match.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!dec_hit &&
                port_addr[port_lsb(i, W_WIDTH) +: W_WIDTH] == hdr_q) begin
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
        if (BCAST_EN && hdr_q == {W_WIDTH{BCAST_BIT}}) begin
            dec_sel = '1;
            dec_hit = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        hdr_last_d   = hdr_last_q;
        sel_d        = sel_q;
        wr_en_d      = '0;
        data_out_d   = data_out_q;
        drop_d       = 1'b0;
        wd_timeout_d = 1'b0;
        wd_arm       = 1'b0;
        wd_feed      = 1'b0;
        ready        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (sw_en) begin
                    hdr_d      = data_in;
                    hdr_last_d = sw_last;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                sel_d = dec_sel;
                if (!dec_hit) begin
                    drop_d  = 1'b1;
                    state_d = hdr_last_q ? S_IDLE : S_DROP;
                end else begin
                    wd_feed = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_arm = 1'b1;
                // An issue in the expiry cycle still goes through.
                if (egress_free) begin
                    wr_en_d    = sel_q;
                    data_out_d = hdr_q;
                    if (hdr_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        wd_feed = 1'b1;
                        state_d = S_FWD;
                    end
                end else if (wd_expire) begin
                    drop_d       = 1'b1;
                    wd_timeout_d = 1'b1;
                    state_d      = S_DROP;
                end
            end
            S_FWD: begin
                wd_arm = 1'b1;
                ready  = egress_free;
                if (sw_en && egress_free) begin
                    wr_en_d    = sel_q;
                    data_out_d = data_in;
                    wd_feed    = 1'b1;
                    if (sw_last) begin
                        state_d = S_IDLE;
                    end
                end else if (wd_expire) begin
                    drop_d       = 1'b1;
                    wd_timeout_d = 1'b1;
                    state_d      = S_DROP;
                end
            end
            S_DROP: begin
                ready = 1'b1;
                if (sw_en && sw_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            hdr_q        <= '0;
            hdr_last_q   <= 1'b0;
            sel_q        <= '0;
            wr_en_q      <= '0;
            data_out_q   <= '0;
            drop_q       <= 1'b0;
            wd_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            hdr_last_q   <= hdr_last_d;
            sel_q        <= sel_d;
            wr_en_q      <= wr_en_d;
            data_out_q   <= data_out_d;
            drop_q       <= drop_d;
            wd_timeout_q <= wd_timeout_d;
        end
    end

    switch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .arm    (wd_arm),
        .feed   (wd_feed),
        .expire (wd_expire)
    );

    // Hold the source off for the whole reset pulse.
    assign sw_ready   = ready & ~rst;
    assign wr_en      = wr_en_q;
    assign data_out   = data_out_q;
    assign drop       = drop_q;
    assign wd_timeout = wd_timeout_q;

endmodule

// File: tb/tb_switch_fwd_ctrl.sv
// Bench for switch_fwd_ctrl: packet-level scoreboard plus directed
// packets with literal expectations.
module tb_switch_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw_en = 1'b0;
    logic        sw_last = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        sw_ready;
    logic [31:0] port_addr;
    logic [3:0]  port_busy = 4'h0;
    logic [3:0]  wr_en;
    logic [7:0]  data_out;
    logic        drop;
    logic        wd_timeout;

    logic [7:0] addrs [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    assign port_addr = {addrs[3], addrs[2], addrs[1], addrs[0]};

    switch_fwd_ctrl #(
        .W_WIDTH   (8),
        .NUM_PORTS (4),
        .TIMEOUT   (4),
        .BCAST_EN  (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_en      (sw_en),
        .sw_last    (sw_last),
        .data_in    (data_in),
        .sw_ready   (sw_ready),
        .port_addr  (port_addr),
        .port_busy  (port_busy),
        .wr_en      (wr_en),
        .data_out   (data_out),
        .drop       (drop),
        .wd_timeout (wd_timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    endtask

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] d;
        int         due;
        bit         exact;
        bit         hdr;
    } exp_t;

    typedef struct packed {
        logic [3:0] we;
        logic [7:0] d;
        int         n;
    } wr_t;

    typedef enum {M_IDLE, M_FWD, M_DISC} mmode_t;

    exp_t       expq[$];
    wr_t        wlog[$];
    mmode_t     mode = M_IDLE;
    logic [3:0] cur_route = 4'h0;
    bit         pend_drop = 0;
    bit         pend_wd = 0;
    bit         drop_seen = 0;
    bit         hdr_out = 0;
    int         ncnt = 0;
    int         hdr_count = 0;
    int         hdr_n = 0;
    int         wd_n = 0;
    int         n_drop = 0;
    int         n_wd = 0;

    bit         exact_hdr = 1;
    bit         expect_wd = 0;
    bit         abort = 0;
    logic [7:0] pkt[$];

    function automatic logic [3:0] route_of(input logic [7:0] a);
        if (a == 8'hFF) return 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (addrs[i] == a) return 4'(1 << i);
        end
        return 4'h0;
    endfunction

    always @(negedge clk) begin : cmp
        exp_t e;
        ncnt++;
        if (rst) begin
            check("rst_wr_en", {28'h0, wr_en}, 32'h0);
            check("rst_ready", {31'h0, sw_ready}, 32'h0);
            check("rst_pulses", {30'h0, drop, wd_timeout}, 32'h0);
            expq.delete();
            mode = M_IDLE;
            pend_drop = 0;
            pend_wd = 0;
            drop_seen = 0;
            hdr_out = 0;
        end else begin
            if (wr_en != 4'h0) begin
                wlog.push_back(wr_t'{wr_en, data_out, ncnt});
                if (expq.size() == 0) begin
                    check("unexpected_write", {28'h0, wr_en}, 32'h0);
                end else begin
                    e = expq.pop_front();
                    check("wr_en", {28'h0, wr_en}, {28'h0, e.sel});
                    check("data_out", {24'h0, data_out}, {24'h0, e.d});
                    if (e.exact) check("wr_cycle", ncnt, e.due);
                    else check("wr_cycle_min", {31'h0, ncnt >= e.due}, 1);
                    if (e.hdr) hdr_out = 1;
                end
            end
            if (wd_timeout) begin
                n_wd++;
                wd_n = ncnt;
                check("wd_expected", {31'h0, pend_wd}, 1);
                check("wd_with_drop", {31'h0, drop}, 1);
                pend_wd = 0;
            end else if (drop) begin
                check("wd_missing", {31'h0, pend_wd}, 0);
            end
            if (drop) begin
                n_drop++;
                check("drop_expected", {31'h0, pend_drop}, 1);
                pend_drop = 0;
                drop_seen = 1;
            end
            if (mode == M_FWD && hdr_out)
                check("ready_fwd", {31'h0, sw_ready},
                      {31'h0, (port_busy & cur_route) == 4'h0});
            else if (mode == M_DISC && drop_seen)
                check("ready_drop", {31'h0, sw_ready}, 1);
            else if (mode == M_IDLE && expq.size() == 0 && !pend_drop)
                check("ready_idle", {31'h0, sw_ready}, 1);
            if (sw_en && sw_ready) begin
                if (mode == M_IDLE) begin
                    cur_route = route_of(data_in);
                    hdr_count++;
                    hdr_n = ncnt;
                    hdr_out = 0;
                    drop_seen = 0;
                    if (expect_wd) begin
                        pend_drop = 1;
                        pend_wd = 1;
                        mode = sw_last ? M_IDLE : M_DISC;
                    end else if (cur_route == 4'h0) begin
                        pend_drop = 1;
                        mode = sw_last ? M_IDLE : M_DISC;
                    end else begin
                        expq.push_back(exp_t'{cur_route, data_in, ncnt + 3,
                                              exact_hdr, 1'b1});
                        mode = sw_last ? M_IDLE : M_FWD;
                    end
                end else if (mode == M_FWD) begin
                    expq.push_back(exp_t'{cur_route, data_in, ncnt + 1,
                                          1'b1, 1'b0});
                    if (sw_last) mode = M_IDLE;
                end else if (sw_last) begin
                    mode = M_IDLE;
                end
            end
        end
    end

    task automatic wait_accept(output bit ok);
        bit seen;
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (abort) return;
            seen = sw_ready;
            @(posedge clk);
            #1;
            if (seen) begin
                ok = 1;
                return;
            end
        end
        n_total++;
        $display("FAIL accept_bound: no handshake in 200 cycles, want one");
    endtask

    task automatic send_pkt();
        bit ok;
        for (int i = 0; i < pkt.size(); i++) begin
            sw_en = 1;
            data_in = pkt[i];
            sw_last = (i == pkt.size() - 1);
            wait_accept(ok);
            if (!ok) break;
        end
        sw_en = 0;
        sw_last = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_hdr(input int h0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (hdr_count != h0) break;
        end
        check("hdr_seen", {31'h0, hdr_count != h0}, 1);
    endtask

    initial begin
        int b, d0, w0, h0;
        idle(3);
        rst = 0;
        @(negedge clk);
        #1;
        check("reset_wr_en", {28'h0, wr_en}, 32'h0);
        check("reset_data_out", {24'h0, data_out}, 32'h0);
        check("reset_drop", {31'h0, drop}, 0);
        check("reset_wd", {31'h0, wd_timeout}, 0);
        check("reset_ready", {31'h0, sw_ready}, 1);
        idle(1);

        // unicast to port 2, no back-pressure
        b = wlog.size();
        exact_hdr = 1;
        pkt = {8'h30, 8'hA1, 8'hA2};
        send_pkt();
        idle(4);
        check("t1_count", wlog.size() - b, 3);
        if (wlog.size() - b >= 3) begin
            for (int i = 0; i < 3; i++)
                check("t1_we", {28'h0, wlog[b+i].we}, 32'h4);
            check("t1_d0", {24'h0, wlog[b].d}, 32'h30);
            check("t1_d1", {24'h0, wlog[b+1].d}, 32'hA1);
            check("t1_d2", {24'h0, wlog[b+2].d}, 32'hA2);
            check("t1_consec", wlog[b+2].n - wlog[b].n, 2);
            check("t1_hdr_lat", wlog[b].n - hdr_n, 3);
        end

        // no match
        b = wlog.size();
        d0 = n_drop;
        w0 = n_wd;
        pkt = {8'h55, 8'hB1, 8'hB2};
        send_pkt();
        idle(4);
        check("t2_writes", wlog.size() - b, 0);
        check("t2_drops", n_drop - d0, 1);
        check("t2_wd", n_wd - w0, 0);

        // watchdog expiry in WAIT
        b = wlog.size();
        d0 = n_drop;
        w0 = n_wd;
        port_busy = 4'b0010;
        expect_wd = 1;
        pkt = {8'h20, 8'hC1, 8'hC2};
        send_pkt();
        idle(3);
        expect_wd = 0;
        port_busy = 4'h0;
        idle(2);
        check("t3_writes", wlog.size() - b, 0);
        check("t3_drops", n_drop - d0, 1);
        check("t3_wd", n_wd - w0, 1);
        check("t3_wd_cycle", wd_n - hdr_n, 6);

        // broadcast, freed exactly in the expiry cycle
        b = wlog.size();
        d0 = n_drop;
        w0 = n_wd;
        h0 = hdr_count;
        exact_hdr = 0;
        port_busy = 4'b0100;
        pkt = {8'hFF, 8'hD1, 8'hD2};
        fork
            send_pkt();
            begin
                wait_hdr(h0);
                repeat (4) @(posedge clk);
                #1 port_busy = 4'h0;
                repeat (2) @(posedge clk);
                #1 port_busy = 4'b0001;
                repeat (2) @(posedge clk);
                #1 port_busy = 4'h0;
            end
        join
        idle(4);
        check("t4_count", wlog.size() - b, 3);
        if (wlog.size() - b >= 3) begin
            check("t4_we", {28'h0, wlog[b].we}, 32'hF);
            check("t4_d0", {24'h0, wlog[b].d}, 32'hFF);
            check("t4_hdr_cycle", wlog[b].n - hdr_n, 6);
            check("t4_d2", {24'h0, wlog[b+2].d}, 32'hD2);
        end
        check("t4_wd", n_wd - w0, 0);
        check("t4_drops", n_drop - d0, 0);

        // toggling busy, then a stall released in the expiry cycle
        b = wlog.size();
        d0 = n_drop;
        w0 = n_wd;
        port_busy = 4'b1000;
        pkt = {8'h40, 8'hE1, 8'hE2, 8'hE3, 8'hE4,
               8'hE5, 8'hE6, 8'hE7, 8'hE8};
        fork
            send_pkt();
            begin
                bit hit;
                hit = 0;
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk);
                    #1 port_busy[3] = ~port_busy[3];
                end
                for (int i = 0; i < 50; i++) begin
                    @(posedge clk);
                    #1;
                    if (wr_en != 4'h0) begin
                        hit = 1;
                        break;
                    end
                    port_busy[3] = ~port_busy[3];
                end
                check("t5_write_seen", {31'h0, hit}, 1);
                port_busy[3] = 1'b1;
                repeat (3) @(posedge clk);
                #1 port_busy = 4'h0;
            end
        join
        idle(4);
        check("t5_count", wlog.size() - b, 9);
        if (wlog.size() - b >= 9) begin
            for (int i = 0; i < 9; i++) begin
                check("t5_we", {28'h0, wlog[b+i].we}, 32'h8);
                check("t5_data", {24'h0, wlog[b+i].d}, {24'h0, pkt[i]});
            end
        end
        check("t5_wd", n_wd - w0, 0);
        check("t5_drops", n_drop - d0, 0);

        // reset mid-payload
        b = wlog.size();
        exact_hdr = 1;
        pkt = {8'h10, 8'hF1, 8'hF2, 8'hF3, 8'hF4};
        fork
            send_pkt();
            begin
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk);
                    #1;
                    if (wlog.size() >= b + 2) break;
                end
                check("t6_reach", {31'h0, wlog.size() >= b + 2}, 1);
                rst = 1;
                abort = 1;
                repeat (2) @(posedge clk);
                #1 rst = 0;
            end
        join
        abort = 0;
        idle(2);
        check("t6_truncated", wlog.size() - b, 2);
        b = wlog.size();
        pkt = {8'h20, 8'h91, 8'h92};
        send_pkt();
        idle(4);
        check("t6_after_count", wlog.size() - b, 3);
        if (wlog.size() - b >= 3) begin
            check("t6_we", {28'h0, wlog[b].we}, 32'h2);
            check("t6_d0", {24'h0, wlog[b].d}, 32'h20);
            check("t6_d2", {24'h0, wlog[b+2].d}, 32'h92);
        end

        check("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/switch_fwd_ctrl.md
# switch_fwd_ctrl

Multi-port forwarding controller for the simple switch: accepts a packet stream whose first beat is a destination address, matches it against NUM_PORTS programmable port addresses (plus optional broadcast), and forwards header and payload to the selected egress port(s) under per-port back-pressure. A built-in watchdog aborts packets stalled too long on a busy port or an idle source. It replaces the single-port FSM/watchdog pair in the switch top level.

## Interface
- W_WIDTH, 8, data/address width
- NUM_PORTS, 4, egress port count (1..16)
- TIMEOUT, 16, watchdog limit in cycles (>=2)
- BCAST_EN, 1, 1: address all-ones selects every port
---
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- sw_en  in  1  input beat valid
- sw_last  in  1  marks final beat of packet (valid with sw_en)
- data_in  in  W_WIDTH  beat data; first beat = destination address
- sw_ready  out  1  beat accepted on edge where sw_en && sw_ready
- port_addr  in  NUM_PORTS*W_WIDTH  port i address at [i*W_WIDTH +: W_WIDTH]
- port_busy  in  NUM_PORTS  egress i cannot accept a beat
- wr_en  out  NUM_PORTS  registered one-hot (or all-ones for broadcast) write strobe
- data_out  out  W_WIDTH  registered beat to egress
- drop  out  1  one-cycle pulse: packet discarded (no match or timeout)
- wd_timeout  out  1  one-cycle pulse: watchdog expired

## Operation
- States: IDLE, DECODE, WAIT, FWD, DROP.
- IDLE: sw_ready=1. Accepted beat -> hdr<=data_in, hdr_last<=sw_last, go DECODE.
- DECODE (1 cycle, sw_ready=0): sel = lowest-index i with port_addr[i]==hdr; if BCAST_EN and hdr all-ones, sel = all ports (overrides match). No match -> drop pulse next cycle; go IDLE if hdr_last else DROP. Match -> feed watchdog, go WAIT.
- WAIT (sw_ready=0): when (port_busy & sel)==0, issue hdr to sel; go IDLE if hdr_last else FWD (feed watchdog). Watchdog expiry -> DROP, drop and wd_timeout pulse.
- FWD: sw_ready = ((port_busy & sel)==0). Each accepted beat is issued and feeds the watchdog; accepted beat with sw_last -> IDLE. Expiry -> DROP with pulses (egress sees truncated packet).
- DROP: sw_ready=1; discard beats until accepted beat with sw_last -> IDLE. Watchdog disarmed.
- Issue: on the edge the beat/header is issued, wr_en<=sel, data_out<=beat; otherwise wr_en<=0, data_out holds.
- Simultaneous: WAIT/FWD issue and watchdog expiry in same cycle -> issue wins, watchdog refed. sw_en in DECODE/WAIT ignored (source holds beat).

## Timing
- Reset: state IDLE, wr_en=0, data_out=0, drop=0, wd_timeout=0, sel=0, hdr=0; sw_ready=0 while rst high.
- Reset mid-packet: immediate return to IDLE, packet lost, no pulses.
- Latency: header accepted edge k -> DECODE cycle k+1 -> earliest wr_en in cycle k+3 (WAIT issue at edge k+2). Payload: accepted at edge k -> wr_en/data_out valid cycle k+1, high exactly one cycle.
- Sustained throughput in FWD: one beat per cycle while egress not busy.
- Watchdog: feed loads TIMEOUT; decrements each armed cycle; expiry pulse in the TIMEOUT-th cycle after the feed cycle with no intervening feed; state leaves on that edge; drop/wd_timeout high the following cycle.
- Counter width $clog2(TIMEOUT+1); no wrap (stops at 0, disarmed).

## Structure
- Shared package switch_pkg: state encoding localparams, broadcast address constant, port-address slice helper.
- Sub-module switch_wdog (TIMEOUT param; ports clk, rst, arm, feed, expire), one instance.
- FSM, decoder and output registers in switch_fwd_ctrl.

## Test plan
- Port addresses 0x10,0x20,0x30,0x40; packet 0x30,0xA1,0xA2(last), no busy -> wr_en=4'b0100 for three consecutive cycles, data_out 0x30,0xA1,0xA2.
- Header 0x55 (no match), 3-beat packet -> wr_en never set, drop pulse once, sw_ready=1 through remaining beats, returns to IDLE.
- TIMEOUT=4, header 0x20, port_busy[1] held high -> wd_timeout and drop pulse, DROP state; source's remaining beats consumed, no wr_en.
- Header 0xFF with BCAST_EN=1, port_busy[2] high 3 cycles -> header held in WAIT, then wr_en=4'b1111 with data_out 0xFF; payload back-pressured whenever any port busy.
- FWD with port_busy toggling every other cycle -> sw_ready mirrors it, no beat lost or duplicated; simultaneous free+expiry -> beat issued, no timeout.
- rst asserted mid-payload -> wr_en=0 and sw_ready=0 immediately; after release next packet forwards normally.
